// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM channel: FSM state encoding and
// the configuration record used for both the shadow and the active register sets.
package pwm_pkg;

  localparam int PWM_CNT_W   = 16;
  localparam int PWM_PRESC_W = 8;

  typedef enum logic {
    PWM_IDLE = 1'b0,
    PWM_RUN  = 1'b1
  } pwm_state_t;

  typedef struct packed {
    logic [PWM_CNT_W-1:0]   period;
    logic [PWM_CNT_W-1:0]   duty;
    logic [PWM_PRESC_W-1:0] presc;
    logic                   pol;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: tick is high one cycle out of every (div+1) while clr is low.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = PWM_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign tick = !clr && (r_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// Single PWM channel with double-buffered configuration; shadow values are
// applied on enable and at period ends so a running period never glitches.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PRESC_W = PWM_PRESC_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               cfg_en_i,
  input  logic               cfg_wr_i,
  input  logic [CNT_W-1:0]   cfg_period_i,
  input  logic [CNT_W-1:0]   cfg_duty_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  input  logic               cfg_pol_i,
  output logic               pwm_o,
  output logic               pwm_oeb_o,
  output logic               irq_o,
  output logic               pending_o,
  output logic [CNT_W-1:0]   cnt_o,
  output pwm_state_t         dbg_state_o
);

  pwm_state_t       r_state;
  pwm_state_t       w_next;
  pwm_cfg_t         r_shadow;
  pwm_cfg_t         r_act;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_irq;
  logic             r_pwm;
  logic             w_tick;
  logic             w_presc_clr;
  logic             w_period_end;
  logic             w_load;
  logic             w_pwm_nxt;

  // Prescaler is held clear outside RUN and on the disable cycle.
  assign w_presc_clr = (r_state != PWM_RUN) || !cfg_en_i;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (w_presc_clr),
    .div   (r_act.presc),
    .tick  (w_tick)
  );

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_cnt_nxt    = '0;
    w_pwm_nxt    = r_act.pol;
    w_period_end = 1'b0;
    case (r_state)
      PWM_IDLE: begin
        if (cfg_en_i) begin
          w_next = PWM_RUN;
          w_load = 1'b1;
        end
      end
      PWM_RUN: begin
        w_pwm_nxt = r_act.pol ^ (r_cnt < r_act.duty);
        if (!cfg_en_i) begin
          w_next = PWM_IDLE;
        end else begin
          w_period_end = w_tick && (r_cnt == r_act.period);
          w_load       = w_period_end && r_pending;
          if (w_period_end) begin
            w_cnt_nxt = '0;
          end else if (w_tick) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
      end
      default: w_next = PWM_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= PWM_IDLE;
      r_shadow  <= '0;
      r_act     <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_period_end;
      r_pwm   <= w_pwm_nxt;
      // A write landing on a transfer cycle keeps pending set for the next one.
      if (cfg_wr_i) begin
        r_shadow  <= '{period: cfg_period_i, duty: cfg_duty_i,
                       presc: cfg_presc_i, pol: cfg_pol_i};
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
      if (w_load) begin
        r_act <= r_shadow;
      end
    end
  end

  assign pwm_o       = r_pwm;
  assign pwm_oeb_o   = (r_state != PWM_RUN);
  assign irq_o       = r_irq;
  assign pending_o   = r_pending;
  assign cnt_o       = r_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pwm_channel.sv
// Directed bench for pwm_channel: table of waveform vectors plus hand-written
// sequences for shadow updates, disable/re-enable and asynchronous reset.
module tb_pwm_channel;
  import pwm_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        wr     = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] duty   = '0;
  logic [7:0]  presc  = '0;
  logic        pol    = 1'b0;

  logic        pwm;
  logic        oeb;
  logic        irq;
  logic        pending;
  logic [15:0] cnt;
  pwm_state_t  st;

  int checks = 0;
  int errors = 0;

  // len = clocks per period, act = clocks at active level at the start of each period
  typedef struct {
    logic [15:0] period;
    logic [15:0] duty;
    logic [7:0]  presc;
    logic        pol;
    int          len;
    int          act;
  } vec_t;

  vec_t vecs[6];

  pwm_channel u_dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .cfg_en_i     (en),
    .cfg_wr_i     (wr),
    .cfg_period_i (period),
    .cfg_duty_i   (duty),
    .cfg_presc_i  (presc),
    .cfg_pol_i    (pol),
    .pwm_o        (pwm),
    .pwm_oeb_o    (oeb),
    .irq_o        (irq),
    .pending_o    (pending),
    .cnt_o        (cnt),
    .dbg_state_o  (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [15:0] p, input logic [15:0] d,
                           input logic [7:0] ps, input logic pl);
    period = p;
    duty   = d;
    presc  = ps;
    pol    = pl;
    wr     = 1'b1;
    step();
    wr     = 1'b0;
  endtask

  // Sample n (n>=1) after the enabling edge sits at phase (n-1) mod len.
  task automatic check_wave(input string tag, input int n, input int len,
                            input int act, input logic pl);
    int   p;
    logic exp_pwm;
    logic exp_irq;
    p       = (n - 1) % len;
    exp_pwm = (p < act) ? ~pl : pl;
    exp_irq = (p == len - 1);
    check($sformatf("%s pwm n=%0d", tag, n), {31'd0, pwm}, {31'd0, exp_pwm});
    check($sformatf("%s irq n=%0d", tag, n), {31'd0, irq}, {31'd0, exp_irq});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pwm"},     {31'd0, pwm},     32'd0);
    check({tag, " oeb"},     {31'd0, oeb},     32'd1);
    check({tag, " irq"},     {31'd0, irq},     32'd0);
    check({tag, " pending"}, {31'd0, pending}, 32'd0);
    check({tag, " cnt"},     {16'd0, cnt},     32'd0);
    check({tag, " state"},   {31'd0, st},      {31'd0, PWM_IDLE});
  endtask

  initial begin
    vecs[0] = '{period: 16'd4, duty: 16'd2,  presc: 8'd0, pol: 1'b0, len: 5,  act: 2};
    vecs[1] = '{period: 16'd3, duty: 16'd1,  presc: 8'd1, pol: 1'b1, len: 8,  act: 2};
    vecs[2] = '{period: 16'd9, duty: 16'd0,  presc: 8'd0, pol: 1'b0, len: 10, act: 0};
    vecs[3] = '{period: 16'd9, duty: 16'd10, presc: 8'd0, pol: 1'b0, len: 10, act: 10};
    vecs[4] = '{period: 16'd0, duty: 16'd1,  presc: 8'd0, pol: 1'b0, len: 1,  act: 1};
    vecs[5] = '{period: 16'd2, duty: 16'd1,  presc: 8'd2, pol: 1'b0, len: 9,  act: 3};

    // clock/reset
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // table-driven waveforms
    for (int i = 0; i < 6; i++) begin
      en = 1'b0;
      step();
      step();
      write_cfg(vecs[i].period, vecs[i].duty, vecs[i].presc, vecs[i].pol);
      check($sformatf("v%0d pending after wr", i), {31'd0, pending}, 32'd1);
      en = 1'b1;
      step();
      check($sformatf("v%0d oeb after en", i), {31'd0, oeb}, 32'd0);
      check($sformatf("v%0d pending after en", i), {31'd0, pending}, 32'd0);
      check($sformatf("v%0d cnt start", i), {16'd0, cnt}, 32'd0);
      for (int n = 1; n <= 2 * vecs[i].len + 2; n++) begin
        step();
        check_wave($sformatf("v%0d", i), n, vecs[i].len, vecs[i].act, vecs[i].pol);
        check($sformatf("v%0d oeb n=%0d", i, n), {31'd0, oeb}, 32'd0);
      end
    end

    // shadow update mid-period, then a write coinciding with the period end
    en = 1'b0;
    step();
    step();
    write_cfg(16'd9, 16'd5, 8'd0, 1'b0);
    en = 1'b1;
    step();
    for (int n = 1; n <= 40; n++) begin
      int   a;
      logic exp_pend;
      step();
      a        = (n <= 10) ? 5 : ((n <= 30) ? 8 : 2);
      exp_pend = (n >= 4 && n <= 9) || (n >= 20 && n <= 29);
      check_wave("shadow", n, 10, a, 1'b0);
      check($sformatf("shadow pending n=%0d", n), {31'd0, pending}, {31'd0, exp_pend});
      if (n == 3)  duty = 16'd8;
      if (n == 19) duty = 16'd2;
      wr = (n == 3) || (n == 19);
    end
    wr = 1'b0;

    // disable at cnt=2, then re-enable
    en = 1'b0;
    step();
    step();
    write_cfg(16'd9, 16'd5, 8'd0, 1'b1);
    en = 1'b1;
    step();
    step();
    step();
    check("dis cnt before", {16'd0, cnt}, 32'd2);
    en = 1'b0;
    step();
    check("dis state", {31'd0, st},  {31'd0, PWM_IDLE});
    check("dis oeb",   {31'd0, oeb}, 32'd1);
    check("dis cnt",   {16'd0, cnt}, 32'd0);
    check("dis irq",   {31'd0, irq}, 32'd0);
    check("dis pwm lag", {31'd0, pwm}, 32'd0);
    step();
    check("dis pwm inactive", {31'd0, pwm}, 32'd1);
    check("dis oeb later",    {31'd0, oeb}, 32'd1);
    check("dis irq later",    {31'd0, irq}, 32'd0);
    en = 1'b1;
    step();
    check("reen cnt start", {16'd0, cnt}, 32'd0);
    for (int n = 1; n <= 3; n++) begin
      step();
      check($sformatf("reen cnt n=%0d", n), {16'd0, cnt}, n);
      check_wave("reen", n, 10, 5, 1'b1);
    end

    // asynchronous reset mid-RUN
    write_cfg(16'd9, 16'd5, 8'd0, 1'b1);
    step();
    step();
    check("pre-rst pwm",     {31'd0, pwm},     32'd1);
    check("pre-rst pending", {31'd0, pending}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async rst");
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post-rst oeb",   {31'd0, oeb}, 32'd1);
    check("post-rst state", {31'd0, st},  {31'd0, PWM_IDLE});
    check("post-rst cnt",   {16'd0, cnt}, 32'd0);
    en = 1'b1;
    step();
    for (int n = 1; n <= 3; n++) begin
      step();
      check($sformatf("zero-shadow pwm n=%0d", n), {31'd0, pwm}, 32'd0);
      check($sformatf("zero-shadow irq n=%0d", n), {31'd0, irq}, 32'd1);
      check($sformatf("zero-shadow cnt n=%0d", n), {16'd0, cnt}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
